// File: rtl/gate_stim_sequencer.sv
// gate_stim_sequencer: timed 4-bit stimulus sequencer for the gate block, driving {a,b,c,d} with busy/done status.
// Optional MISR signature over resp when GATE_STIM_MISR_EN is defined.
module gate_stim_sequencer #(
  parameter int         NUM_VEC   = 16,
  parameter int         HOLD_W    = 8,
  parameter logic [3:0] LFSR_SEED = 4'b1001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [3:0]        pattern_in,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic [7:0]        vec_idx,
  input  logic [9:0]        resp,
  output logic [9:0]        signature
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [7:0] LAST = 8'(NUM_VEC - 1);
  state_t            state;
  logic [1:0]        mode_r;
  logic [HOLD_W-1:0] hold_r, hold_cnt, hold_eff;
  logic [3:0]        vec, nxt, first;
  logic              accept;
  always_comb begin
    nxt      = mode_r == 2'd0 ? vec + 4'd1 :
               mode_r == 2'd1 ? {vec[2:0], vec[3]} :
               mode_r == 2'd2 ? {vec[2:0], vec[3] ^ vec[2]} : vec;
    first    = (mode == 2'd2 && pattern_in == 4'd0) ? LFSR_SEED : pattern_in;
    hold_eff = hold_r == '0 ? HOLD_W'(1) : hold_r;
    accept   = start && state != RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      vec      <= '0;
      vec_idx  <= '0;
      hold_cnt <= '0;
      hold_r   <= '0;
      mode_r   <= '0;
    end else if (abort) begin
      state   <= IDLE;
      vec     <= '0;
      vec_idx <= '0;
    end else if (accept) begin
      state    <= RUN;
      mode_r   <= mode;
      hold_r   <= hold_cycles;
      vec      <= first;
      vec_idx  <= '0;
      hold_cnt <= HOLD_W'(1);
    end else if (state == RUN) begin
      if (hold_cnt == hold_eff) begin
        if (vec_idx == LAST) begin
          state   <= DONE;
          vec     <= '0;
          vec_idx <= '0;
        end else begin
          vec      <= nxt;
          vec_idx  <= vec_idx + 8'd1;
          hold_cnt <= HOLD_W'(1);
        end
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
  assign {a, b, c, d} = vec;
  assign valid = state == RUN;
  assign busy  = state == RUN;
  assign done  = state == DONE;
`ifdef GATE_STIM_MISR_EN
  // abort freezes the signature; the final vector's cycle is still compacted
  always_ff @(posedge clk) begin
    if (reset) signature <= '0;
    else if (!abort) begin
      if (accept) signature <= '0;
      else if (valid) signature <= {signature[8:0], signature[9] ^ signature[6]} ^ resp;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^resp;
  assign signature   = '0;
`endif
endmodule
